data_mem_stage: RTL and testbench

//  Parametrised MEM pipeline stage: byte-lane data memory, sized/signed loads,

---
 rtl/dm_pkg.sv | 17 +
 rtl/dm_ram.sv | 29 ++
 rtl/data_mem_stage.sv | 159 +++++++++++++++
 tb/tb_data_mem_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and the
// writeback mux select values.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic MUX_ANS = 1'b0;
    localparam logic MUX_MEM = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } dm_state_e;

endpackage

// File: rtl/dm_ram.sv
// DEPTH x DW data array with per-byte write enables; synchronous write,
// asynchronous read. Contents are deliberately not reset.
module dm_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [DW/8-1:0]   we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DW-1:0]     wdata_i,
    output logic [DW-1:0]     rdata_o
);

    localparam int NB = DW / 8;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_stage.sv
// MEM pipeline stage: byte-lane data memory, sized/signed loads, optional
// wait states with a stall handshake, and the writeback result mux.
//
//  state   | meaning
//  ST_IDLE | ready; completes at once when MEM_LAT=0, else accepts and starts waiting
//  ST_WAIT | access in flight; commits and registers the result when cnt reaches 0
module data_mem_stage
    import dm_pkg::*;
#(
    parameter int DW      = 32,
    parameter int DEPTH   = 256,
    parameter int RW_W    = 5,
    parameter int MEM_LAT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   ans_ex,
    input  logic [DW-1:0]   B_Bypass,
    input  logic [RW_W-1:0] RW_ex,
    input  logic            valid_ex,
    input  logic            mem_en_ex,
    input  logic            mem_rw_ex,
    input  logic [1:0]      mem_size_ex,
    input  logic            mem_uns_ex,
    input  logic            mem_mux_sel_ex,
    output logic [DW-1:0]   mux_ans_dm,
    output logic [RW_W-1:0] RW_dm,
    output logic            valid_dm,
    output logic            misalign_dm,
    output logic            stall_dm
);

    localparam int AW      = $clog2(DEPTH);
    localparam int NB      = DW / 8;
    localparam int BL      = $clog2(NB);
    localparam bit NO_WAIT = (MEM_LAT == 0);

    dm_state_e       state_q;
    logic [3:0]      cnt_q;
    logic [DW-1:0]   mux_ans_q;
    logic [RW_W-1:0] rw_q;
    logic            valid_q;
    logic            misalign_q;

    logic            mem_op;
    logic            misalign;
    logic            bad_op;
    logic            complete;
    logic [BL-1:0]   offset;
    logic [AW-1:0]   word_idx;
    logic [NB-1:0]   lane_mask;
    logic [NB-1:0]   byte_we;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    logic [DW-1:0]   rshift;
    logic [DW-1:0]   load_ext;
    logic [DW-1:0]   result;

    assign mem_op   = valid_ex & mem_en_ex;
    assign offset   = ans_ex[BL-1:0];
    assign word_idx = ans_ex[AW+BL-1:BL];

    always_comb begin
        misalign  = 1'b0;
        lane_mask = '1;
        case (mem_size_ex)
            SZ_BYTE: lane_mask = {{(NB-1){1'b0}}, 1'b1};
            SZ_HALF: begin
                lane_mask = {{(NB-2){1'b0}}, 2'b11};
                misalign  = offset[0];
            end
            default: misalign = |offset;
        endcase
    end

    assign bad_op = mem_op & misalign;

    // With no wait states every accepted op completes on the next edge.
    assign complete = mem_op & (NO_WAIT | ((state_q == ST_WAIT) & (cnt_q == 4'd0)));

    assign byte_we = (complete & mem_rw_ex & ~misalign) ? (lane_mask << offset) : '0;
    assign wdata   = B_Bypass << {offset, 3'b000};

    dm_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (byte_we),
        .addr_i  (word_idx),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    assign rshift = rdata >> {offset, 3'b000};

    always_comb begin
        load_ext = rshift;
        case (mem_size_ex)
            SZ_BYTE: load_ext = {{(DW-8){~mem_uns_ex & rshift[7]}}, rshift[7:0]};
            SZ_HALF: load_ext = {{(DW-16){~mem_uns_ex & rshift[15]}}, rshift[15:0]};
            default: load_ext = rshift;
        endcase
    end

    assign result = bad_op ? '0 :
                    (mem_op & (mem_mux_sel_ex == MUX_MEM)) ? load_ext : ans_ex;

    // Gated by reset so the handshake reads idle while the stage is held in reset.
    assign stall_dm = reset & ~NO_WAIT & ((state_q == ST_IDLE) ? mem_op : (cnt_q != 4'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mux_ans_q  <= '0;
            rw_q       <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!NO_WAIT && mem_op) begin
                        state_q    <= ST_WAIT;
                        cnt_q      <= 4'(MEM_LAT - 1);
                        valid_q    <= 1'b0;
                        misalign_q <= 1'b0;
                    end else begin
                        mux_ans_q  <= result;
                        rw_q       <= RW_ex;
                        valid_q    <= valid_ex;
                        misalign_q <= bad_op;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q      <= cnt_q - 4'd1;
                        valid_q    <= 1'b0;
                        misalign_q <= 1'b0;
                    end else begin
                        state_q    <= ST_IDLE;
                        mux_ans_q  <= result;
                        rw_q       <= RW_ex;
                        valid_q    <= valid_ex;
                        misalign_q <= bad_op;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mux_ans_dm  = mux_ans_q;
    assign RW_dm       = rw_q;
    assign valid_dm    = valid_q;
    assign misalign_dm = misalign_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Bench for data_mem_stage: two instances (no wait states, three wait states)
// checked against a byte-addressed memory model every cycle.
module tb_data_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n    [2] = '{1'b1, 1'b1};
    logic [31:0] ans_ex   [2] = '{32'd0, 32'd0};
    logic [31:0] b_byp    [2] = '{32'd0, 32'd0};
    logic [4:0]  rw_ex    [2] = '{5'd0, 5'd0};
    logic        valid_ex [2] = '{1'b0, 1'b0};
    logic        mem_en   [2] = '{1'b0, 1'b0};
    logic        mem_rw   [2] = '{1'b0, 1'b0};
    logic [1:0]  mem_size [2] = '{2'd0, 2'd0};
    logic        mem_uns  [2] = '{1'b0, 1'b0};
    logic        mem_sel  [2] = '{1'b0, 1'b0};

    logic [31:0] mux_ans  [2];
    logic [4:0]  rw_dm    [2];
    logic        valid_dm [2];
    logic        mis_dm   [2];
    logic        stall_dm [2];

    logic        exp_stall [2] = '{1'b0, 1'b0};
    logic        exp_valid [2] = '{1'b0, 1'b0};
    logic        exp_mis   [2] = '{1'b0, 1'b0};
    logic [31:0] exp_ans   [2] = '{32'd0, 32'd0};
    logic [4:0]  exp_rw    [2] = '{5'd0, 5'd0};

    logic [7:0]  mem_b [2][1024];
    bit          started = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    data_mem_stage #(.DW(32), .DEPTH(256), .RW_W(5), .MEM_LAT(0)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .ans_ex(ans_ex[0]), .B_Bypass(b_byp[0]),
        .RW_ex(rw_ex[0]), .valid_ex(valid_ex[0]), .mem_en_ex(mem_en[0]),
        .mem_rw_ex(mem_rw[0]), .mem_size_ex(mem_size[0]), .mem_uns_ex(mem_uns[0]),
        .mem_mux_sel_ex(mem_sel[0]), .mux_ans_dm(mux_ans[0]), .RW_dm(rw_dm[0]),
        .valid_dm(valid_dm[0]), .misalign_dm(mis_dm[0]), .stall_dm(stall_dm[0])
    );

    data_mem_stage #(.DW(32), .DEPTH(256), .RW_W(5), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(rst_n[1]), .ans_ex(ans_ex[1]), .B_Bypass(b_byp[1]),
        .RW_ex(rw_ex[1]), .valid_ex(valid_ex[1]), .mem_en_ex(mem_en[1]),
        .mem_rw_ex(mem_rw[1]), .mem_size_ex(mem_size[1]), .mem_uns_ex(mem_uns[1]),
        .mem_mux_sel_ex(mem_sel[1]), .mux_ans_dm(mux_ans[1]), .RW_dm(rw_dm[1]),
        .valid_dm(valid_dm[1]), .misalign_dm(mis_dm[1]), .stall_dm(stall_dm[1])
    );

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, d, $time, got, exp);
        end
    endtask

    // Little-endian byte memory; returns the writeback value and misalign flag.
    task automatic model(input int d, input bit v, input bit en, input bit rw, input logic [1:0] sz,
                         input bit uns, input bit sel, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output bit mis);
        int n, addr;
        logic [31:0] val;
        logic [7:0] fill;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        addr = int'(a & 32'h3FF);
        mis  = 1'b0;
        res  = a;
        if (v && en) begin
            if (addr % n != 0) begin
                mis = 1'b1;
                res = 32'd0;
            end else begin
                if (rw) for (int i = 0; i < n; i++) mem_b[d][addr+i] = b[8*i +: 8];
                val = 32'd0;
                for (int i = 0; i < n; i++) val[8*i +: 8] = mem_b[d][addr+i];
                fill = (!uns && val[8*n-1]) ? 8'hFF : 8'h00;
                for (int i = n; i < 4; i++) val[8*i +: 8] = fill;
                if (sel) res = val;
            end
        end
    endtask

    task automatic issue(input int d, input bit v, input bit en, input bit rw, input logic [1:0] sz,
                         input bit uns, input bit sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rwi);
        logic [31:0] res;
        bit mis;
        int lat;
        @(negedge clk);
        ans_ex[d] = a; b_byp[d] = b; rw_ex[d] = rwi; valid_ex[d] = v; mem_en[d] = en;
        mem_rw[d] = rw; mem_size[d] = sz; mem_uns[d] = uns; mem_sel[d] = sel;
        lat = (v && en) ? ((d == 0) ? 0 : 3) : 0;
        for (int k = 0; k < lat; k++) begin
            exp_stall[d] = 1'b1; exp_valid[d] = 1'b0; exp_mis[d] = 1'b0;
            @(negedge clk);
        end
        model(d, v, en, rw, sz, uns, sel, a, b, res, mis);
        exp_stall[d] = 1'b0; exp_valid[d] = v; exp_ans[d] = res; exp_rw[d] = rwi; exp_mis[d] = mis;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        valid_ex[d] = 1'b0; mem_en[d] = 1'b0;
        exp_stall[d] = 1'b0; exp_valid[d] = 1'b0; exp_mis[d] = 1'b0;
    endtask

    task automatic check_zero(input int d);
        chk("rst_mux", d, mux_ans[d], 32'd0);
        chk("rst_rw", d, {27'd0, rw_dm[d]}, 32'd0);
        chk("rst_valid", d, {31'd0, valid_dm[d]}, 32'd0);
        chk("rst_mis", d, {31'd0, mis_dm[d]}, 32'd0);
        chk("rst_stall", d, {31'd0, stall_dm[d]}, 32'd0);
    endtask

    always @(negedge clk) begin
        #1;
        if (started) for (int d = 0; d < 2; d++) chk("stall", d, {31'd0, stall_dm[d]}, {31'd0, exp_stall[d]});
    end

    always @(posedge clk) begin
        #1;
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                chk("valid", d, {31'd0, valid_dm[d]}, {31'd0, exp_valid[d]});
                chk("misalign", d, {31'd0, mis_dm[d]}, {31'd0, exp_mis[d]});
                if (exp_valid[d]) begin
                    chk("mux_ans", d, mux_ans[d], exp_ans[d]);
                    chk("rw_dm", d, {27'd0, rw_dm[d]}, {27'd0, exp_rw[d]});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] sz;
        bit v, en, rw, uns, sel;
        int kind;

        #1 rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        #1 started = 1'b1;
        check_zero(0);
        check_zero(1);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 256; w++) issue(d, 1, 1, 1, 2'd2, 0, 0, 32'(w * 4), $urandom, 5'd1);
            idle(d);
        end

        // Directed, no wait states
        issue(0, 1, 1, 1, 2'd2, 0, 0, 32'h10, 32'hDEADBEEF, 5'd3);
        issue(0, 1, 1, 0, 2'd2, 0, 1, 32'h10, 32'd0, 5'd7);
        chk("ld_word", 0, mux_ans[0], 32'hDEADBEEF);
        chk("ld_word_valid", 0, {31'd0, valid_dm[0]}, 32'd1);
        chk("ld_word_rw", 0, {27'd0, rw_dm[0]}, 32'd7);
        issue(0, 1, 1, 1, 2'd0, 0, 0, 32'h13, 32'h00000080, 5'd2);
        issue(0, 1, 1, 0, 2'd0, 0, 1, 32'h13, 32'd0, 5'd4);
        chk("ld_byte_s", 0, mux_ans[0], 32'hFFFFFF80);
        issue(0, 1, 1, 0, 2'd0, 1, 1, 32'h13, 32'd0, 5'd4);
        chk("ld_byte_u", 0, mux_ans[0], 32'h00000080);
        issue(0, 1, 1, 0, 2'd2, 0, 1, 32'h10, 32'd0, 5'd5);
        chk("ld_word2", 0, mux_ans[0], 32'h80ADBEEF);
        issue(0, 1, 1, 0, 2'd1, 0, 1, 32'h11, 32'd0, 5'd6);
        chk("mis_half_flag", 0, {31'd0, mis_dm[0]}, 32'd1);
        chk("mis_half_ans", 0, mux_ans[0], 32'd0);
        chk("mis_half_rw", 0, {27'd0, rw_dm[0]}, 32'd6);
        issue(0, 1, 1, 1, 2'd1, 0, 0, 32'h11, 32'h0000AAAA, 5'd6);
        issue(0, 1, 1, 0, 2'd2, 0, 1, 32'h10, 32'd0, 5'd8);
        chk("after_mis_st", 0, mux_ans[0], 32'h80ADBEEF);
        issue(0, 1, 1, 0, 2'd1, 0, 1, 32'h12, 32'd0, 5'd8);
        chk("ld_half_s", 0, mux_ans[0], 32'hFFFF80AD);
        issue(0, 1, 0, 0, 2'd0, 0, 0, 32'h55, 32'd0, 5'd9);
        chk("alu_pass", 0, mux_ans[0], 32'h55);
        issue(0, 1, 1, 0, 2'd2, 0, 1, 32'h410, 32'd0, 5'd10);
        chk("wrap_alias", 0, mux_ans[0], 32'h80ADBEEF);

        @(negedge clk);
        ans_ex[0] = 32'h14; valid_ex[0] = 1'b1; mem_en[0] = 1'b1; mem_rw[0] = 1'b0;
        rst_n[0] = 1'b0;
        exp_stall[0] = 1'b0; exp_valid[0] = 1'b0; exp_mis[0] = 1'b0;
        #1 check_zero(0);
        @(negedge clk);
        rst_n[0] = 1'b1; valid_ex[0] = 1'b0; mem_en[0] = 1'b0;

        // Directed, three wait states
        issue(1, 1, 1, 1, 2'd2, 0, 0, 32'h40, 32'hCAFEF00D, 5'd11);
        chk("lat_store_valid", 1, {31'd0, valid_dm[1]}, 32'd1);
        issue(1, 1, 1, 0, 2'd2, 0, 1, 32'h40, 32'd0, 5'd12);
        chk("lat_ld_word", 1, mux_ans[1], 32'hCAFEF00D);
        @(negedge clk);
        ans_ex[1] = 32'h40; b_byp[1] = 32'h11111111; valid_ex[1] = 1'b1; mem_en[1] = 1'b1;
        mem_rw[1] = 1'b1; mem_size[1] = 2'd2; mem_sel[1] = 1'b0;
        exp_stall[1] = 1'b1; exp_valid[1] = 1'b0; exp_mis[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n[1] = 1'b0;
        exp_stall[1] = 1'b0;
        #1 check_zero(1);
        @(negedge clk);
        rst_n[1] = 1'b1; valid_ex[1] = 1'b0; mem_en[1] = 1'b0;
        issue(1, 1, 1, 0, 2'd2, 0, 1, 32'h40, 32'd0, 5'd13);
        chk("abort_no_store", 1, mux_ans[1], 32'hCAFEF00D);
        issue(1, 1, 0, 0, 2'd0, 0, 0, 32'h55, 32'd0, 5'd14);
        chk("lat_alu_pass", 1, mux_ans[1], 32'h55);

        // Randomized traffic
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 300; n++) begin
                kind = $urandom_range(0, 9);
                v    = (kind != 0);
                en   = (kind >= 3) || (kind == 0 && $urandom_range(0, 1) == 1);
                rw   = $urandom_range(0, 1) == 1;
                sz   = 2'($urandom_range(0, 3));
                uns  = $urandom_range(0, 1) == 1;
                sel  = en ? (!rw && $urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
                issue(d, v, en, rw, sz, uns, sel, $urandom, $urandom, 5'($urandom_range(0, 31)));
            end
            idle(d);
        end
        idle(0);
        @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
